// File: rtl/roi_pkg.sv
// rtl/roi_pkg.sv - coordinate field positions, FSM state type and corner normalisation for roi_crop_axis
package roi_pkg;

    localparam int X_LSB   = 16;
    localparam int Y_LSB   = 0;
    localparam int COORD_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } roi_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } roi_bounds_t;

    // Corners may be given in any order; bounds are inclusive.
    function automatic roi_bounds_t roi_normalise(
        input logic [COORD_W-1:0] x0,
        input logic [COORD_W-1:0] x1,
        input logic [COORD_W-1:0] y0,
        input logic [COORD_W-1:0] y1
    );
        roi_bounds_t b;
        b.xmin = (x0 < x1) ? x0 : x1;
        b.xmax = (x0 < x1) ? x1 : x0;
        b.ymin = (y0 < y1) ? y0 : y1;
        b.ymax = (y0 < y1) ? y1 : y0;
        return b;
    endfunction

endpackage

// File: rtl/roi_axis_reg.sv
// rtl/roi_axis_reg.sv - one-deep registered stream output stage with ready/valid handshake
module roi_axis_reg #(
    parameter int W = 24
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         i_load,
    input  logic [W-1:0] i_tdata,
    input  logic         i_tuser,
    input  logic         i_tlast,
    output logic         o_tready,
    output logic         o_tvalid,
    output logic [W-1:0] o_tdata,
    output logic         o_tuser,
    output logic         o_tlast,
    input  logic         i_tready
);

    logic         r_tvalid;
    logic [W-1:0] r_tdata;
    logic         r_tuser;
    logic         r_tlast;

    assign o_tready = !r_tvalid || i_tready;
    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_tuser  = r_tuser;
    assign o_tlast  = r_tlast;

    // i_load is only raised on an accepted beat, so it never arrives while stalled.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (o_tready) begin
            r_tvalid <= i_load;
            if (i_load) begin
                r_tdata <= i_tdata;
                r_tuser <= i_tuser;
                r_tlast <= i_tlast;
            end
        end
    end

endmodule

// File: rtl/roi_crop_axis.sv
// rtl/roi_crop_axis.sv - crops a raster video stream to a latched rectangle, with bypass and error flag
module roi_crop_axis
    import roi_pkg::*;
#(
    parameter int CH    = 3,
    parameter int BIT_D = 8,
    parameter int BIT_C = 32,
    parameter int X_W   = 11,
    parameter int Y_W   = 10
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [CH*BIT_D-1:0] tdata_i,
    input  logic                tvalid_i,
    output logic                tready_o,
    input  logic                tuser_i,
    input  logic                tlast_i,
    input  logic [BIT_C-1:0]    xy_0_i,
    input  logic [BIT_C-1:0]    xy_1_i,
    input  logic                bypass_i,
    output logic [CH*BIT_D-1:0] tdata_o,
    output logic                tvalid_o,
    input  logic                tready_i,
    output logic                tuser_o,
    output logic                tlast_o,
    output logic                roi_err_o
);

    localparam int DW = CH * BIT_D;

    roi_state_e     r_state;
    logic [X_W-1:0] r_x_cnt, r_xmin, r_xmax;
    logic [Y_W-1:0] r_y_cnt, r_ymin, r_ymax;
    logic           r_first;
    logic           r_err;

    logic           w_tready, w_accept, w_sof, w_active;
    roi_bounds_t    w_new;
    logic [X_W-1:0] w_cx, w_xmin, w_xmax;
    logic [Y_W-1:0] w_cy, w_ymin, w_ymax;
    logic           w_in_x, w_in_y, w_fwd;
    logic           w_out_user, w_out_last;
    logic           w_short_line, w_short_frame;
    logic           w_unused;

    assign tready_o = w_tready;
    assign w_accept = tvalid_i && w_tready;
    assign w_sof    = w_accept && tuser_i;
    assign w_active = w_sof || (r_state == ACTIVE);

    assign w_new = roi_normalise(COORD_W'(xy_0_i[X_LSB +: X_W]), COORD_W'(xy_1_i[X_LSB +: X_W]),
                                 COORD_W'(xy_0_i[Y_LSB +: Y_W]), COORD_W'(xy_1_i[Y_LSB +: Y_W]));
    assign w_unused = ^{xy_0_i, xy_1_i, w_new};

    // The SOF beat is pixel (0,0) of the new frame and is judged against the new bounds.
    assign w_cx   = w_sof ? '0 : r_x_cnt;
    assign w_cy   = w_sof ? '0 : r_y_cnt;
    assign w_xmin = w_sof ? w_new.xmin[X_W-1:0] : r_xmin;
    assign w_xmax = w_sof ? w_new.xmax[X_W-1:0] : r_xmax;
    assign w_ymin = w_sof ? w_new.ymin[Y_W-1:0] : r_ymin;
    assign w_ymax = w_sof ? w_new.ymax[Y_W-1:0] : r_ymax;

    assign w_in_x = (w_cx >= w_xmin) && (w_cx <= w_xmax);
    assign w_in_y = (w_cy >= w_ymin) && (w_cy <= w_ymax);
    assign w_fwd  = w_accept && w_active && (bypass_i || (w_in_x && w_in_y));

    assign w_out_user = bypass_i ? tuser_i : (w_sof || r_first);
    assign w_out_last = bypass_i ? tlast_i : (tlast_i || (w_cx == w_xmax));

    assign w_short_line  = w_accept && w_active && tlast_i && w_in_y && (w_cx < w_xmax);
    assign w_short_frame = w_sof && (r_state == ACTIVE) && (r_y_cnt <= r_ymax);

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state <= IDLE;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymin  <= '0;
            r_ymax  <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_sof) begin
                r_state <= ACTIVE;
                r_xmin  <= w_xmin;
                r_xmax  <= w_xmax;
                r_ymin  <= w_ymin;
                r_ymax  <= w_ymax;
                r_first <= !w_fwd;
            end else if (w_fwd) begin
                r_first <= 1'b0;
            end

            if (w_accept && w_active) begin
                if (tlast_i) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= (&w_cy) ? w_cy : w_cy + Y_W'(1);
                end else begin
                    r_x_cnt <= (&w_cx) ? w_cx : w_cx + X_W'(1);
                    r_y_cnt <= w_cy;
                end
            end

            // A short-frame event belongs to the frame being closed, so the SOF clear wins.
            if (w_sof) begin
                r_err <= 1'b0;
            end else if (w_short_line || w_short_frame) begin
                r_err <= 1'b1;
            end
        end
    end

    assign roi_err_o = r_err;

    roi_axis_reg #(
        .W(DW)
    ) u_out_reg (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .i_load   (w_fwd),
        .i_tdata  (tdata_i),
        .i_tuser  (w_out_user),
        .i_tlast  (w_out_last),
        .o_tready (w_tready),
        .o_tvalid (tvalid_o),
        .o_tdata  (tdata_o),
        .o_tuser  (tuser_o),
        .o_tlast  (tlast_o),
        .i_tready (tready_i)
    );

endmodule

// File: doc/roi_crop_axis.md
# roi_crop_axis

Parametrised multi-channel region-of-interest cropper for AXI4-Stream video. Accepts a full raster frame (SOF on `tuser`, EOL on `tlast`) and forwards only pixels inside a rectangle given by two corner registers. It adds several things the first-generation ROI block lacks:
- downstream backpressure;
- per-frame coordinate latching;
- corner normalisation;
- a bypass mode;
- an out-of-frame error flag.

It sits between the pixel source and the downstream video pipeline.

## Interface
Parameters:
- `CH`, default 3: channels per pixel.
- `BIT_D`, default 8: bits per channel.
- `BIT_C`, default 32: width of a coordinate register.
- `X_W`, default 11: x-coordinate width. Occupies bits [16+X_W-1:16] of a coordinate register.
- `Y_W`, default 10: y-coordinate width. Occupies bits [Y_W-1:0] of a coordinate register.

Ports:
- `clk_i`, in, 1: single clock, all logic on the rising edge.
- `arst_i`, in, 1: asynchronous reset, active-low (0 = reset). Assertion is asynchronous; deassertion is synchronous to `clk_i`.
- `tdata_i`, in, CH*BIT_D: input pixel. Channel k is at [k*BIT_D +: BIT_D].
- `tvalid_i`, in, 1: input beat valid.
- `tready_o`, out, 1: block can accept an input beat.
- `tuser_i`, in, 1: start of frame (first pixel of a frame).
- `tlast_i`, in, 1: end of input line.
- `xy_0_i`, in, BIT_C: corner 0. x in [26:16], y in [9:0].
- `xy_1_i`, in, BIT_C: corner 1, same layout as corner 0.
- `bypass_i`, in, 1: when 1, every beat is forwarded unchanged.
- `tdata_o`, out, CH*BIT_D: output pixel.
- `tvalid_o`, out, 1: output beat valid.
- `tready_i`, in, 1: downstream can accept a beat.
- `tuser_o`, out, 1: first ROI pixel of a frame.
- `tlast_o`, out, 1: last ROI pixel of a line.
- `roi_err_o`, out, 1: sticky error. Cleared at the next accepted SOF.

## Operation
- **Input handshake.** An input beat is accepted when `tvalid_i && tready_o`. `tready_o = !tvalid_o || tready_i`.
- **States.** The FSM has two states, IDLE and ACTIVE, and is in IDLE after reset.
  - IDLE: accepted beats with `tuser_i=0` are dropped.
  - Any accepted beat with `tuser_i=1`, in either state, does the following:
    - enters ACTIVE;
    - latches both corners;
    - sets x_cnt=0, y_cnt=0;
    - clears `roi_err_o`.
- **Corner normalisation at latch.**
  - xmin = min(x0,x1), xmax = max(x0,x1).
  - ymin and ymax are formed the same way.
  - Bounds are inclusive.
  - Corner inputs are ignored between SOFs.
- **ACTIVE state.**
  - The beat is inside the ROI iff xmin ≤ x_cnt ≤ xmax and ymin ≤ y_cnt ≤ ymax.
  - Inside beats are forwarded; outside beats are consumed and dropped.
- **Output flags.**
  - `tlast_o=1` on an inside beat with x_cnt==xmax, or on an inside beat with `tlast_i=1`.
  - `tuser_o=1` on the first forwarded beat after an SOF.
- **Counters.**
  - On every accepted beat in ACTIVE: if `tlast_i`, x_cnt←0 and y_cnt←y_cnt+1; else x_cnt←x_cnt+1.
  - Both counters saturate at all-ones and never wrap.
- **Error flag.** `roi_err_o` is set when either of these occurs:
  - `tlast_i` is accepted on a line where ymin ≤ y_cnt ≤ ymax and x_cnt < xmax (line shorter than the ROI);
  - an SOF arrives while y_cnt ≤ ymax of the previous frame (frame shorter than the ROI).
  - When the set and clear events coincide, the error refers to the old frame and the clear wins.
- **Bypass.** With `bypass_i=1`, every accepted beat is forwarded, with tuser/tlast copied from the input. Counters still run. `bypass_i` is sampled per beat.

## Timing
- **Latency.** One cycle from the accepted input beat to `tvalid_o`. The output is a single register stage.
- **Output register update.**
  - The register loads when `tready_o` is high and the beat is forwarded.
  - It clears `tvalid_o` when `tready_i` is high and nothing is forwarded.
  - It holds while `tvalid_o && !tready_i`.
- **Stall behaviour.**
  - `tdata_o`/`tuser_o`/`tlast_o` are stable while `tvalid_o && !tready_i`.
  - Counters advance only on accepted beats.
- **Throughput.** One beat per cycle with `tready_i` held at 1.
- **Reset values.**
  - `tvalid_o`, `tdata_o`, `tuser_o`, `tlast_o`, `roi_err_o` are all 0.
  - FSM is in IDLE; counters and latched bounds are 0.
  - Hence `tready_o` is 1 (it follows `!tvalid_o`).
- **Reset mid-frame.** Any in-flight output beat is discarded. After release, the block waits for the next SOF.

## Structure
- Package `roi_pkg`:
  - the field-extraction constants (X_LSB=16, Y_LSB=0);
  - the state enum {IDLE, ACTIVE};
  - a function returning a normalised bounds struct {xmin, xmax, ymin, ymax}.
- One sub-module, `roi_axis_reg`: the one-deep output register and handshake. It is reusable elsewhere in the pipeline.
- Top level holds the FSM, counters, bounds, compare logic and error logic.

## Test plan
- **Basic crop.** 8×4 frame with corners (2,1) and (4,2), `tready_i=1`.
  - Exactly 6 beats out, at pixels x=2..4 on rows y=1..2.
  - `tuser_o` on (2,1); `tlast_o` on (4,1) and (4,2).
  - `roi_err_o`=0.
- **Corner normalisation.** Same frame with corners swapped, (4,2) and (2,1). Output is identical to the basic-crop case.
- **Backpressure.** Drive `tready_i` with a 1-0-0-1 pattern during the basic-crop case.
  - No beat is lost or duplicated.
  - Data is stable while stalled.
  - Output sequence is unchanged.
- **Short line.** ROI x-range 2..9 on an 8-wide frame.
  - `tlast_o` on x=7 for each ROI row.
  - `roi_err_o`=1 after the first ROI line; it clears at the next SOF.
- **Bypass and pre-SOF beats.** Send 5 beats before any SOF, then a frame with `bypass_i=1`.
  - The first 5 beats are dropped.
  - All 32 pixels of the frame pass, with flags copied from the input.
- **Reset mid-frame.** Assert `arst_i=0` during row 1.
  - All outputs go to 0 immediately.
  - Post-reset beats without `tuser_i` are dropped until the next SOF.
